// File: rtl/vga_if.sv
// VGA pixel-stream bundle: timing counters, sync/blank flags and 12-bit colour.
interface vga_if;
    logic [11:0] hcount;
    logic [11:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_cursor.sv
// Sprite-cursor overlay stage: 2-bit sprite, integer up-scale, blink and invert,
// with position/enables latched at vblank start to avoid tearing.
module draw_cursor #(
    parameter int unsigned SPRITE_W     = 16,
    parameter int unsigned SPRITE_H     = 16,
    parameter int unsigned SCALE_LOG2   = 0,
    parameter int unsigned BLINK_FRAMES = 30,
    parameter logic [11:0] COLOR_A      = 12'hFFF,
    parameter logic [11:0] COLOR_B      = 12'h000
) (
    input  logic                                  clk,
    input  logic                                  rst,
    vga_if.in                                     vga_in,
    vga_if.out                                    vga_out,
    input  logic [11:0]                           xpos,
    input  logic [11:0]                           ypos,
    input  logic                                  enable,
    input  logic                                  blink_en,
    input  logic                                  spr_we,
    input  logic [$clog2(SPRITE_W*SPRITE_H)-1:0]  spr_addr,
    input  logic [1:0]                            spr_data,
    output logic                                  cursor_hit
);

    localparam int unsigned NPIX  = SPRITE_W * SPRITE_H;
    localparam int unsigned AW    = $clog2(NPIX);
    localparam int unsigned CW    = $clog2(BLINK_FRAMES + 1);
    localparam logic [12:0] WIN_W = 13'(SPRITE_W << SCALE_LOG2);
    localparam logic [12:0] WIN_H = 13'(SPRITE_H << SCALE_LOG2);

    logic [1:0]    mem_q [NPIX];
    logic [1:0]    mem_d [NPIX];

    logic          vblnk_prev_q;
    logic [11:0]   x_lat_q, x_lat_d;
    logic [11:0]   y_lat_q, y_lat_d;
    logic          en_lat_q, en_lat_d;
    logic          bl_lat_q, bl_lat_d;
    logic [CW-1:0] frame_cnt_q, frame_cnt_d;
    logic          phase_q, phase_d;

    logic          win_q, win_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [11:0]   rgb_q;
    logic [11:0]   hcount_q, vcount_q;
    logic          hsync_q, vsync_q, hblnk_q, vblnk_q;

    logic [11:0]   out_rgb_q, out_rgb_d;
    logic          hit_q, hit_d;
    logic [11:0]   out_hcount_q, out_vcount_q;
    logic          out_hsync_q, out_vsync_q, out_hblnk_q, out_vblnk_q;

    logic          vb_start;
    logic [12:0]   dx, dy;
    logic [1:0]    code;

    always_comb begin
        mem_d = mem_q;
        if (spr_we) mem_d[spr_addr] = spr_data;
    end

    always_comb begin
        vb_start    = vga_in.vblnk & ~vblnk_prev_q;
        x_lat_d     = x_lat_q;
        y_lat_d     = y_lat_q;
        en_lat_d    = en_lat_q;
        bl_lat_d    = bl_lat_q;
        frame_cnt_d = frame_cnt_q;
        phase_d     = phase_q;
        if (vb_start) begin
            x_lat_d  = xpos;
            y_lat_d  = ypos;
            en_lat_d = enable;
            bl_lat_d = blink_en;
            // The freshly latched blink enable decides this frame's counter step.
            if (!blink_en) begin
                frame_cnt_d = '0;
                phase_d     = 1'b1;
            end else if (frame_cnt_q == CW'(BLINK_FRAMES - 1)) begin
                frame_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + CW'(1);
            end
        end
    end

    always_comb begin
        dx     = {1'b0, vga_in.hcount} - {1'b0, x_lat_q};
        dy     = {1'b0, vga_in.vcount} - {1'b0, y_lat_q};
        win_d  = !dx[12] && (dx < WIN_W) && !dy[12] && (dy < WIN_H) &&
                 !vga_in.hblnk && !vga_in.vblnk && en_lat_q && phase_q;
        // Only meaningful inside the window, where the shifted offsets fit the sprite.
        addr_d = AW'((32'(dy) >> SCALE_LOG2) * SPRITE_W + (32'(dx) >> SCALE_LOG2));
    end

    always_comb begin
        code      = mem_q[addr_q];
        out_rgb_d = rgb_q;
        hit_d     = 1'b0;
        if (win_q) begin
            case (code)
                2'b01: begin out_rgb_d = COLOR_A; hit_d = 1'b1; end
                2'b10: begin out_rgb_d = COLOR_B; hit_d = 1'b1; end
                2'b11: begin out_rgb_d = ~rgb_q;  hit_d = 1'b1; end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q        <= '{default: '0};
            vblnk_prev_q <= 1'b0;
            x_lat_q      <= '0;
            y_lat_q      <= '0;
            en_lat_q     <= 1'b0;
            bl_lat_q     <= 1'b0;
            frame_cnt_q  <= '0;
            phase_q      <= 1'b1;
            win_q        <= 1'b0;
            addr_q       <= '0;
            rgb_q        <= '0;
            hcount_q     <= '0;
            vcount_q     <= '0;
            hsync_q      <= 1'b0;
            vsync_q      <= 1'b0;
            hblnk_q      <= 1'b0;
            vblnk_q      <= 1'b0;
            out_rgb_q    <= '0;
            hit_q        <= 1'b0;
            out_hcount_q <= '0;
            out_vcount_q <= '0;
            out_hsync_q  <= 1'b0;
            out_vsync_q  <= 1'b0;
            out_hblnk_q  <= 1'b0;
            out_vblnk_q  <= 1'b0;
        end else begin
            mem_q        <= mem_d;
            vblnk_prev_q <= vga_in.vblnk;
            x_lat_q      <= x_lat_d;
            y_lat_q      <= y_lat_d;
            en_lat_q     <= en_lat_d;
            bl_lat_q     <= bl_lat_d;
            frame_cnt_q  <= frame_cnt_d;
            phase_q      <= phase_d;
            win_q        <= win_d;
            addr_q       <= addr_d;
            rgb_q        <= vga_in.rgb;
            hcount_q     <= vga_in.hcount;
            vcount_q     <= vga_in.vcount;
            hsync_q      <= vga_in.hsync;
            vsync_q      <= vga_in.vsync;
            hblnk_q      <= vga_in.hblnk;
            vblnk_q      <= vga_in.vblnk;
            out_rgb_q    <= out_rgb_d;
            hit_q        <= hit_d;
            out_hcount_q <= hcount_q;
            out_vcount_q <= vcount_q;
            out_hsync_q  <= hsync_q;
            out_vsync_q  <= vsync_q;
            out_hblnk_q  <= hblnk_q;
            out_vblnk_q  <= vblnk_q;
        end
    end

    assign vga_out.hcount = out_hcount_q;
    assign vga_out.vcount = out_vcount_q;
    assign vga_out.hsync  = out_hsync_q;
    assign vga_out.vsync  = out_vsync_q;
    assign vga_out.hblnk  = out_hblnk_q;
    assign vga_out.vblnk  = out_vblnk_q;
    assign vga_out.rgb    = out_rgb_q;
    assign cursor_hit     = hit_q;

endmodule

// File: tb/tb_draw_cursor.sv
// Randomised bench for draw_cursor: two instances (scale 1x and 2x) share one stimulus
// stream and are compared every cycle against a behavioural pixel/frame model.
module tb_draw_cursor;

    localparam int unsigned SW = 16;
    localparam int unsigned SH = 16;
    localparam int unsigned BF = 2;
    localparam logic [11:0] CA = 12'hFFF;
    localparam logic [11:0] CB = 12'h000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] xpos = '0;
    logic [11:0] ypos = '0;
    logic        enable = 1'b0;
    logic        blink_en = 1'b0;
    logic        spr_we = 1'b0;
    logic [7:0]  spr_addr = '0;
    logic [1:0]  spr_data = '0;
    logic        hit0, hit1;

    vga_if vin ();
    vga_if vo0 ();
    vga_if vo1 ();

    always #5 clk = ~clk;

    draw_cursor #(.SPRITE_W(SW), .SPRITE_H(SH), .SCALE_LOG2(0), .BLINK_FRAMES(BF),
                  .COLOR_A(CA), .COLOR_B(CB)) dut0 (
        .clk(clk), .rst(rst), .vga_in(vin), .vga_out(vo0), .xpos(xpos), .ypos(ypos),
        .enable(enable), .blink_en(blink_en), .spr_we(spr_we), .spr_addr(spr_addr),
        .spr_data(spr_data), .cursor_hit(hit0));

    draw_cursor #(.SPRITE_W(SW), .SPRITE_H(SH), .SCALE_LOG2(1), .BLINK_FRAMES(BF),
                  .COLOR_A(CA), .COLOR_B(CB)) dut1 (
        .clk(clk), .rst(rst), .vga_in(vin), .vga_out(vo1), .xpos(xpos), .ypos(ypos),
        .enable(enable), .blink_en(blink_en), .spr_we(spr_we), .spr_addr(spr_addr),
        .spr_data(spr_data), .cursor_hit(hit1));

    typedef struct packed {
        logic [11:0] hc;
        logic [11:0] vc;
        logic        hs, vs, hb, vb;
        logic [11:0] rgb;
        logic        hit;
    } pix_t;

    int checks = 0;
    int errors = 0;

    int         m_x, m_y, m_cnt;
    bit         m_en, m_bl, m_vis, m_prev;
    logic [1:0] m_spr [SW*SH];
    pix_t       s1 [2];
    pix_t       s2 [2];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic pix_t observed(input int i);
        pix_t o;
        if (i == 0) begin
            o.hc = vo0.hcount; o.vc = vo0.vcount; o.hs = vo0.hsync; o.vs = vo0.vsync;
            o.hb = vo0.hblnk;  o.vb = vo0.vblnk;  o.rgb = vo0.rgb;  o.hit = hit0;
        end else begin
            o.hc = vo1.hcount; o.vc = vo1.vcount; o.hs = vo1.hsync; o.vs = vo1.vsync;
            o.hb = vo1.hblnk;  o.vb = vo1.vblnk;  o.rgb = vo1.rgb;  o.hit = hit1;
        end
        return o;
    endfunction

    task automatic model_reset();
        m_x = 0; m_y = 0; m_cnt = 0;
        m_en = 0; m_bl = 0; m_vis = 1; m_prev = 0;
        for (int i = 0; i < SW*SH; i++) m_spr[i] = 2'b00;
        for (int i = 0; i < 2; i++) begin s1[i] = '0; s2[i] = '0; end
    endtask

    // What the screen should show for one input pixel at on-screen scale 2^s.
    function automatic pix_t model_pix(input int s, input pix_t p);
        pix_t e = p;
        int dx = int'(p.hc) - m_x;
        int dy = int'(p.vc) - m_y;
        int span_w = SW << s;
        int span_h = SH << s;
        e.hit = 1'b0;
        if (!p.hb && !p.vb && m_en && m_vis && dx >= 0 && dx < span_w && dy >= 0 && dy < span_h)
        begin
            case (m_spr[(dy >> s) * SW + (dx >> s)])
                2'b01: begin e.rgb = CA;     e.hit = 1'b1; end
                2'b10: begin e.rgb = CB;     e.hit = 1'b1; end
                2'b11: begin e.rgb = ~p.rgb; e.hit = 1'b1; end
                default: ;
            endcase
        end
        return e;
    endfunction

    task automatic tick(input int hc, input int vc, input logic hb, input logic vb,
                        input logic [11:0] rgb, input logic we, input int a, input logic [1:0] d);
        pix_t o, p;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            o = observed(i);
            check_eq($sformatf("dut%0d timing", i), {o.hc, o.vc, o.hs, o.vs, o.hb, o.vb},
                     {s2[i].hc, s2[i].vc, s2[i].hs, s2[i].vs, s2[i].hb, s2[i].vb});
            check_eq($sformatf("dut%0d rgb/hit", i), {o.rgb, o.hit}, {s2[i].rgb, s2[i].hit});
        end
        p.hc = 12'(hc); p.vc = 12'(vc); p.hs = 1'($urandom_range(0, 1));
        p.vs = 1'($urandom_range(0, 1)); p.hb = hb; p.vb = vb; p.rgb = rgb; p.hit = 1'b0;
        vin.hcount = p.hc; vin.vcount = p.vc; vin.hsync = p.hs; vin.vsync = p.vs;
        vin.hblnk = p.hb;  vin.vblnk = p.vb;  vin.rgb = p.rgb;
        spr_we = we; spr_addr = 8'(a); spr_data = d;
        if (rst) begin
            if (we) m_spr[a] = d;
            for (int i = 0; i < 2; i++) begin
                s2[i] = s1[i];
                s1[i] = model_pix(i, p);
            end
            if (vb && !m_prev) begin
                m_x = int'(xpos); m_y = int'(ypos); m_en = enable; m_bl = blink_en;
                if (!m_bl) begin
                    m_cnt = 0; m_vis = 1;
                end else if (m_cnt == BF - 1) begin
                    m_cnt = 0; m_vis = !m_vis;
                end else begin
                    m_cnt++;
                end
            end
            m_prev = vb;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pixel(input int hc, input int vc, input logic [11:0] rgb);
        tick(hc, vc, hc >= 640, 1'b0, rgb, 1'b0, 0, 2'b00);
    endtask

    task automatic vblank(input int n);
        for (int i = 0; i < n; i++)
            tick($urandom_range(0, 799), 480 + i, 1'b1, 1'b1, 12'($urandom), 1'b0, 0, 2'b00);
    endtask

    task automatic spr_write(input int a, input logic [1:0] d);
        tick(0, 500, 1'b1, 1'b1, 12'($urandom), 1'b1, a, d);
    endtask

    function automatic int clamp(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    task automatic rand_frame(input int n, input bit mutate);
        int hc, vc;
        for (int i = 0; i < n; i++) begin
            hc = $urandom_range(0, 1) ? m_x + int'($urandom_range(0, 40)) - 4
                                      : int'($urandom_range(0, 799));
            vc = $urandom_range(0, 1) ? m_y + int'($urandom_range(0, 40)) - 4
                                      : int'($urandom_range(0, 479));
            hc = clamp(hc, 799);
            vc = clamp(vc, 479);
            if (mutate && $urandom_range(0, 149) == 0) begin
                xpos     = ($urandom_range(0, 9) == 0) ? 12'd4095 : 12'($urandom_range(0, 700));
                ypos     = 12'($urandom_range(0, 470));
                enable   = ($urandom_range(0, 3) != 0);
                blink_en = 1'($urandom_range(0, 1));
            end
            tick(hc, vc, hc >= 640, 1'b0, 12'($urandom),
                 mutate && ($urandom_range(0, 15) == 0), $urandom_range(0, SW*SH-1),
                 2'($urandom));
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("%s dut%0d", tag, i), 64'(observed(i)), 64'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        vin.hcount = '0; vin.vcount = '0; vin.hsync = 1'b0; vin.vsync = 1'b0;
        vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.rgb = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        @(posedge clk); #2 rst = 1'b1;
        for (int x = 0; x < 20; x++) pixel(x, 7, 12'($urandom));

        // Asynchronous reset in the middle of a line, then restart with enable=1 and no vblank.
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_zero_outputs("mid-line reset");
        model_reset();
        enable = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        for (int x = 0; x < 24; x++) pixel(x, x % 3, 12'($urandom));

        // Single COLOR_A pixel at (100,50).
        xpos = 12'd100; ypos = 12'd50; enable = 1'b1; blink_en = 1'b0;
        spr_write(0, 2'b01);
        vblank(4);
        for (int y = 49; y <= 52; y++)
            for (int x = 98; x <= 103; x++) pixel(x, y, 12'($urandom));

        // Invert code over a green background at (10,10).
        xpos = 12'd10; ypos = 12'd10;
        spr_write(0, 2'b11);
        vblank(4);
        for (int y = 9; y <= 12; y++)
            for (int x = 9; x <= 13; x++) pixel(x, y, 12'h0F0);

        for (int a = 0; a < SW*SH; a++) spr_write(a, 2'($urandom));

        // Position change mid-frame only takes effect after the next vblank start.
        xpos = 12'd100; ypos = 12'd290;
        vblank(4);
        for (int f = 0; f < 2; f++) begin
            for (int y = 290; y < 302; y++) begin
                if (f == 0 && y == 296) xpos = 12'd200;
                for (int x = 98; x < 104; x++) pixel(x, y, 12'($urandom));
                for (int x = 198; x < 204; x++) pixel(x, y, 12'($urandom));
            end
            vblank(3);
        end

        // Right-edge clipping, then a fully off-screen cursor.
        xpos = 12'd636; ypos = 12'd100;
        vblank(3);
        for (int y = 100; y < 104; y++)
            for (int x = 630; x < 650; x++) pixel(x, y, 12'($urandom));
        ypos = 12'd4095;
        vblank(3);
        rand_frame(200, 1'b0);
        for (int x = 630; x < 650; x++) pixel(x, 479, 12'($urandom));

        // Blinking, then blink disabled.
        xpos = 12'd300; ypos = 12'd200; blink_en = 1'b1;
        for (int f = 0; f < 10; f++) begin
            vblank(3);
            rand_frame(80, 1'b0);
        end
        blink_en = 1'b0;
        for (int f = 0; f < 3; f++) begin
            vblank(3);
            rand_frame(80, 1'b0);
        end

        // Fully randomised frames with live sprite writes and input changes.
        for (int f = 0; f < 25; f++) begin
            vblank($urandom_range(1, 6));
            rand_frame(300, 1'b1);
        end
        vblank(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/draw_cursor.md
# draw_cursor

Parametrised sprite-cursor overlay on the VGA pixel stream. It is inserted in the `vga_if` chain after the background and rectangle stages. It draws a loadable 2-bit-per-pixel sprite with integer up-scaling, transparency, colour-invert and optional blinking. Cursor position and enables are double-buffered and updated only at the start of vertical blanking, which removes tearing.

## Interface
- `SPRITE_W`, default 16: sprite width in sprite pixels (power of 2, 4..64).
- `SPRITE_H`, default 16: sprite height in sprite pixels (power of 2, 4..64).
- `SCALE_LOG2`, default 0: on-screen scale factor 2^SCALE_LOG2 (0..2).
- `BLINK_FRAMES`, default 30: frames per blink half-period (≥1).
- `COLOR_A`, default 12'hFFF: colour for sprite code 01.
- `COLOR_B`, default 12'h000: colour for sprite code 10.
- `clk` input 1: pixel clock; all logic is on its rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `vga_in` `vga_if.in`: upstream timing and rgb.
- `vga_out` `vga_if.out`: downstream timing and rgb.
- `xpos` input 12: cursor top-left x, in pixels.
- `ypos` input 12: cursor top-left y, in pixels.
- `enable` input 1: cursor display enable.
- `blink_en` input 1: blink mode enable.
- `spr_we` input 1: sprite memory write strobe.
- `spr_addr` input $clog2(SPRITE_W*SPRITE_H): sprite write address, row-major (y*SPRITE_W+x).
- `spr_data` input 2: sprite code to write.
- `cursor_hit` output 1: high when the current `vga_out` pixel was replaced by the cursor (code ≠ 00). Aligned with `vga_out`.

## Operation
- Sprite codes:
  - 00: transparent; pass `rgb_in`.
  - 01: `COLOR_A`.
  - 10: `COLOR_B`.
  - 11: bitwise invert of `rgb_in`.
- Sprite memory is a flop array of SPRITE_W*SPRITE_H 2-bit entries. Reset clears every entry to 00.
  - Write: `spr_data` is stored at `spr_addr` on the clock edge where `spr_we`=1.
  - A read of the same address in that cycle returns the old value.
- Frame latch: a vblank-start event is the cycle where `vga_in.vblnk`=1 and it was 0 in the previous cycle.
  - At that event, `xpos`, `ypos`, `enable` and `blink_en` are captured into `x_lat`, `y_lat`, `en_lat` and `bl_lat`.
  - Changes on these inputs at any other time have no effect until the next vblank start.
  - Reset values: `x_lat`=0, `y_lat`=0, `en_lat`=0, `bl_lat`=0, previous-vblnk=0.
- Blink:
  - The frame counter increments at each vblank start.
  - At BLINK_FRAMES-1 it wraps to 0 and toggles `phase`.
  - When `bl_lat`=0 (after that latch), the counter is held at 0 and `phase` is held at 1.
  - Reset: counter=0, `phase`=1 (visible).
- Hit test, computed from the `vga_in` fields:
  - dx = hcount − x_lat and dy = vcount − y_lat, each 13-bit signed.
  - in-window when 0 ≤ dx < SPRITE_W<<SCALE_LOG2 and 0 ≤ dy < SPRITE_H<<SCALE_LOG2, and `hblnk`=`vblnk`=0, and `en_lat`=1, and `phase`=1.
  - Sprite address = (dy>>SCALE_LOG2)*SPRITE_W + (dx>>SCALE_LOG2).
- Clipping: cursor pixels beyond the active area are never drawn, because blanking suppresses them. Positions up to 4095 are legal and are fully invisible.
- Outside the window, `rgb` passes through unchanged.

## Timing
- Two-stage pipeline:
  - Stage 1 registers the window flag, address, `rgb_in` and all timing fields.
  - Stage 2 reads the sprite, muxes rgb and registers `vga_out` and `cursor_hit`.
- Latency: exactly 2 cycles for every `vga_out` field (hcount, vcount, hsync, vsync, hblnk, vblnk, rgb) and for `cursor_hit`. Timing fields are never altered.
- Latched values captured at vblank start are used for the hit test from the following cycle onward.
- Reset, asynchronous and effective mid-frame:
  - All pipeline registers and `vga_out` fields go to 0, and `cursor_hit`=0.
  - After release, output is valid 2 cycles after the first valid input.
- A sprite write during active video affects pixels read one or more cycles after the write edge; partial-frame updates are permitted.

## Test plan
- Reset: hold `rst`=0 mid-line → all `vga_out` fields =0, `cursor_hit`=0. Release with `enable`=1 and no vblank yet → no cursor drawn, input rgb appears 2 cycles later.
- Static draw (SCALE_LOG2=0): load entry 0 = 01, all others 00. Set xpos=100, ypos=50, enable=1 and pass a vblank → pixel (100,50) outputs 12'hFFF with `cursor_hit`=1; pixel (101,50) outputs `rgb_in`.
- Scale and invert (SCALE_LOG2=1): entry 0 = 11, cursor at (10,10), background 12'h0F0 → pixels (10..11, 10..11) = 12'hF0F; pixel (12,10) passes through.
- Latch: change xpos from 100 to 200 during line 300 → cursor stays at 100 for the rest of the frame and moves to 200 after the next vblank start.
- Blink (BLINK_FRAMES=2, blink_en=1): frames alternate visible/hidden every 2 frames. Deasserting blink_en → cursor visible from the next frame on.
- Edge clip: xpos=636 with a 640-wide mode → only columns 636..639 are drawn. ypos=4095 → no hit for the whole frame.
